prm_edge_sweep: RTL and testbench

- Sequential sweep engine that drives the 15-bit edge code into an array of N_OBS combinational obstacle-check lanes (prm_oblgc_chk*).
- Collects each lane's edge_mask result, gated by per-obstacle occupancy, and packs per-edge "blocked" bits into WORD_W-bit words.
- Sits between the occupancy update logic and the edge-validity bitmap RAM writer.
- One start produces the complete 2^EDGE_W-entry blocked-edge bitmap for the PRM roadmap.

---
 rtl/prm_sweep_pkg.sv | 17 +
 rtl/prm_mask_packer.sv | 48 ++++
 rtl/prm_edge_sweep.sv | 156 +++++++++++++++
 tb/tb_prm_edge_sweep.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_sweep_pkg.sv
// rtl/prm_sweep_pkg.sv - shared widths and state encoding for the PRM edge sweep
package prm_sweep_pkg;

    localparam int DEF_EDGE_W = 15;
    localparam int DEF_N_OBS  = 8;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_LW     = $clog2(DEF_WORD_W);
    localparam int DEF_ADDR_W = DEF_EDGE_W - DEF_LW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/prm_mask_packer.sv
// rtl/prm_mask_packer.sv - collects per-edge blocked bits and latches a full bitmap word
module prm_mask_packer #(
    parameter int WORD_W = 32,
    parameter int LW     = $clog2(WORD_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              set_en_i,
    input  logic [LW-1:0]     idx_i,
    input  logic              bit_i,
    input  logic              latch_i,
    output logic [WORD_W-1:0] word_o
);

    // The top bit never needs storage: it arrives in the same cycle as the latch.
    logic [WORD_W-2:0] pack_q, pack_d;
    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        pack_d = pack_q;
        if (clear_i) begin
            pack_d = '0;
        end else if (set_en_i) begin
            for (int i = 0; i < WORD_W - 1; i++) begin
                if (idx_i == LW'(i)) pack_d[i] = bit_i;
            end
        end
    end

    always_comb begin
        word_d = word_q;
        if (latch_i) word_d = {bit_i, pack_q};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pack_q <= '0;
            word_q <= '0;
        end else begin
            pack_q <= pack_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/prm_edge_sweep.sv
// rtl/prm_edge_sweep.sv - sweeps every edge code through the obstacle lanes and emits blocked bitmap words
module prm_edge_sweep
    import prm_sweep_pkg::*;
#(
    parameter int EDGE_W = DEF_EDGE_W,
    parameter int N_OBS  = DEF_N_OBS,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [N_OBS-1:0]                obs_en_i,
    output logic [EDGE_W-1:0]               edge_code_o,
    input  logic [N_OBS-1:0]                chk_mask_i,
    output logic                            wr_valid_o,
    input  logic                            wr_ready_i,
    output logic [EDGE_W-$clog2(WORD_W)-1:0] wr_addr_o,
    output logic [WORD_W-1:0]               wr_data_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [EDGE_W:0]                 blocked_cnt_o
);

    localparam int LW = $clog2(WORD_W);
    localparam int AW = EDGE_W - LW;

    sweep_state_e     state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N_OBS-1:0] obs_q, obs_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [EDGE_W:0]  cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             valid_q, valid_d;

    logic blocked, last_bit, last_edge, accept;
    logic pack_clear, pack_set, pack_latch;

    assign blocked   = |(chk_mask_i & obs_q);
    assign last_bit  = &edge_q[LW-1:0];
    assign last_edge = &edge_q;
    assign accept    = valid_q & wr_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = SWEEP;
                SWEEP:   if (last_bit) state_d = WRITE;
                WRITE:   if (accept) state_d = last_edge ? DONE : SWEEP;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_d     = (state_d == SWEEP) || (state_d == WRITE);
        done_d     = (state_d == DONE);
        obs_d      = obs_q;
        edge_d     = edge_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        pack_clear = 1'b0;
        pack_set   = 1'b0;
        pack_latch = 1'b0;
        // Abort freezes the datapath; only the pending word is withdrawn.
        if (abort_i) begin
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        obs_d      = obs_en_i;
                        edge_d     = '0;
                        cnt_d      = '0;
                        pack_clear = 1'b1;
                    end
                end
                SWEEP: begin
                    pack_set = 1'b1;
                    cnt_d    = cnt_q + (EDGE_W+1)'(blocked);
                    if (last_bit) begin
                        addr_d     = edge_q[EDGE_W-1:LW];
                        valid_d    = 1'b1;
                        pack_latch = 1'b1;
                    end else begin
                        edge_d = edge_q + EDGE_W'(1);
                    end
                end
                WRITE: begin
                    if (accept) begin
                        valid_d    = 1'b0;
                        pack_clear = 1'b1;
                        if (!last_edge) edge_d = edge_q + EDGE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            obs_q   <= '0;
            edge_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            obs_q   <= obs_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    prm_mask_packer #(
        .WORD_W (WORD_W),
        .LW     (LW)
    ) u_packer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (pack_clear),
        .set_en_i (pack_set),
        .idx_i    (edge_q[LW-1:0]),
        .bit_i    (blocked),
        .latch_i  (pack_latch),
        .word_o   (wr_data_o)
    );

    assign edge_code_o   = edge_q;
    assign wr_valid_o    = valid_q;
    assign wr_addr_o     = addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign blocked_cnt_o = cnt_q;

endmodule

// File: tb/tb_prm_edge_sweep.sv
// tb/tb_prm_edge_sweep.sv - randomized scoreboard bench for prm_edge_sweep
module tb_prm_edge_sweep;

    localparam int EW     = 8;
    localparam int NO     = 8;
    localparam int WW     = 8;
    localparam int LW     = 3;
    localparam int AW     = EW - LW;
    localparam int NEDGE  = 1 << EW;
    localparam int NWORDS = NEDGE / WW;
    localparam int SWEEP_CYC = NWORDS * (WW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          wr_ready = 1'b1;
    logic [NO-1:0] obs_en = '0;
    logic [NO-1:0] chk_mask;
    logic [EW-1:0] edge_code;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [EW:0]   blocked_cnt;

    prm_edge_sweep #(.EDGE_W(EW), .N_OBS(NO), .WORD_W(WW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .abort_i       (abort),
        .obs_en_i      (obs_en),
        .edge_code_o   (edge_code),
        .chk_mask_i    (chk_mask),
        .wr_valid_o    (wr_valid),
        .wr_ready_i    (wr_ready),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .busy_o        (busy),
        .done_o        (done),
        .blocked_cnt_o (blocked_cnt)
    );

    always #5 clk = ~clk;

    // Stub checker lanes: lane l flags edge e when tbl[l][e] is set.
    bit tbl [NO][NEDGE];
    always_comb begin
        chk_mask = '0;
        for (int l = 0; l < NO; l++) chk_mask[l] = tbl[l][edge_code];
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wexp_t;

    wexp_t exq[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    stall_cnt = 0;
    int    exp_cnt = 0;
    int    ready_mode = 0;
    int    stall_left = 0;
    bit    expect_done = 1'b0;
    bit    done_seen = 1'b0;
    bit    done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: wr_ready = 1'b1;
            1: wr_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (stall_left > 0) begin
                    wr_ready = 1'b0;
                    if (wr_valid) stall_left--;
                end else begin
                    wr_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor: sampled mid-cycle, well away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid) begin
                if (exq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required no write", wr_addr, wr_data);
                end else begin
                    check("wr_addr", wr_addr, exq[0].addr);
                    check("wr_data", wr_data, exq[0].data);
                    check("edge_hold", edge_code, int'(exq[0].addr) * WW + WW - 1);
                    if (wr_ready) void'(exq.pop_front());
                    else stall_cnt++;
                end
            end
            if (done_prev) check("done_width", done, 0);
            if (done) begin
                if (!expect_done) begin
                    check("unexpected_done", done, 0);
                end else begin
                    check("blocked_cnt", blocked_cnt, exp_cnt);
                    check("words_left", exq.size(), 0);
                    check("latency", cyc - start_cyc, SWEEP_CYC + stall_cnt);
                    expect_done = 1'b0;
                    done_seen = 1'b1;
                end
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic clear_tbl();
        for (int l = 0; l < NO; l++)
            for (int e = 0; e < NEDGE; e++) tbl[l][e] = 1'b0;
    endtask

    task automatic rand_tbl(input int dens);
        for (int l = 0; l < NO; l++)
            for (int e = 0; e < NEDGE; e++) tbl[l][e] = ($urandom_range(0, 255) < dens);
    endtask

    task automatic issue_sweep(input logic [NO-1:0] obs, input int rmode, input int slen);
        wexp_t w;
        exq.delete();
        exp_cnt = 0;
        for (int a = 0; a < NWORDS; a++) begin
            w.addr = AW'(a);
            w.data = '0;
            for (int i = 0; i < WW; i++) begin
                bit b;
                b = 1'b0;
                for (int l = 0; l < NO; l++) if (obs[l] && tbl[l][a * WW + i]) b = 1'b1;
                w.data[i] = b;
                exp_cnt += int'(b);
            end
            exq.push_back(w);
        end
        @(posedge clk);
        #1;
        ready_mode  = rmode;
        stall_left  = slen;
        stall_cnt   = 0;
        done_seen   = 1'b0;
        expect_done = 1'b1;
        obs_en      = obs;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        obs_en    = NO'($urandom);
    endtask

    task automatic wait_done();
        for (int k = 0; k < SWEEP_CYC * 4 + 200 && !done_seen; k++) @(posedge clk);
        if (!done_seen) check("done_timeout", 0, 1);
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
    endtask

    task automatic run_sweep(input logic [NO-1:0] obs, input int rmode, input int slen, input bit mid_start);
        issue_sweep(obs, rmode, slen);
        if (mid_start) begin
            repeat (50) @(posedge clk);
            #1;
            start  = 1'b1;
            obs_en = ~obs;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done();
    endtask

    task automatic flush();
        expect_done = 1'b0;
        exq.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_edge_code", edge_code, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_blocked_cnt", blocked_cnt, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        rand_tbl(128);
        run_sweep(8'h00, 0, 0, 1'b0);

        clear_tbl();
        tbl[0][5] = 1'b1;
        run_sweep(8'h01, 0, 0, 1'b0);

        clear_tbl();
        for (int e = 0; e < NEDGE; e++) tbl[3][e] = 1'b1;
        run_sweep(8'hF7, 0, 0, 1'b0);
        run_sweep(8'h08, 0, 0, 1'b0);

        rand_tbl(40);
        run_sweep(NO'($urandom), 2, 10, 1'b0);

        issue_sweep(NO'($urandom), 0, 0);
        repeat (99) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        flush();
        check("abort_busy", busy, 0);
        check("abort_wr_valid", wr_valid, 0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_stays_idle", busy, 0);

        rand_tbl(60);
        run_sweep(NO'($urandom), 1, 0, 1'b0);

        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", busy, 0);

        rand_tbl(30);
        run_sweep(NO'($urandom), 0, 0, 1'b1);

        issue_sweep(NO'($urandom), 2, 1000);
        for (int k = 0; k < 100 && !wr_valid; k++) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        flush();
        check("arst_edge_code", edge_code, 0);
        check("arst_wr_valid", wr_valid, 0);
        check("arst_wr_addr", wr_addr, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_busy", busy, 0);
        check("arst_blocked_cnt", blocked_cnt, 0);
        stall_left = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", wr_valid, 0);

        for (int r = 0; r < 16; r++) begin
            rand_tbl($urandom_range(0, 80));
            run_sweep(NO'($urandom), int'($urandom_range(0, 1)), 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
